// File: rtl/text_console_writer.sv
// Character-stream to video-RAM writer: prints characters at a cursor, handles
// LF/CR/BS/FF and clears the screen with word writes after reset or on FF.
module text_console_writer #(
   parameter int          COLS      = 86,
   parameter int          ROWS      = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   input  logic [7:0]              i_char,
   output logic                    o_ready,
   output logic                    o_wr_req,
   input  logic                    i_wr_gnt,
   output logic [31:0]             o_wr_addr,
   output logic [31:0]             o_wr_data,
   output logic [3:0]              o_wr_be,
   output logic [$clog2(COLS)-1:0] o_cur_col,
   output logic [$clog2(ROWS)-1:0] o_cur_row
);

   localparam int CW     = $clog2(COLS);
   localparam int RW     = $clog2(ROWS);
   localparam int NWORDS = (COLS * ROWS + 3) / 4;
   localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   localparam logic [KW-1:0] K_LAST   = KW'(NWORDS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   localparam logic [7:0]  CH_BS    = 8'h08;
   localparam logic [7:0]  CH_LF    = 8'h0A;
   localparam logic [7:0]  CH_FF    = 8'h0C;
   localparam logic [7:0]  CH_CR    = 8'h0D;
   localparam logic [31:0] BLANK_W  = 32'h2020_2020;

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE} state_t;

   state_t        state;
   logic [KW-1:0] clr_k;
   logic          advance;

   logic [CW-1:0] col_adv;
   logic [RW-1:0] row_adv;
   logic [RW-1:0] row_lf;
   logic [31:0]   a_cur;
   logic [31:0]   a_bs;
   logic          accept;
   logic          printable;

   function automatic logic [31:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return BASE_ADDR + 32'(r) * 32'(COLS) + 32'(c);
   endfunction

   function automatic logic [31:0] clear_addr(input logic [KW-1:0] k);
      return (BASE_ADDR + (32'(k) << 2)) & 32'hFFFF_FFFC;
   endfunction

   always_comb begin
      row_lf    = (o_cur_row == ROW_LAST) ? '0 : o_cur_row + RW'(1);
      col_adv   = (o_cur_col == COL_LAST) ? '0 : o_cur_col + CW'(1);
      row_adv   = (o_cur_col == COL_LAST) ? row_lf : o_cur_row;
      a_cur     = cell_addr(o_cur_row, o_cur_col);
      a_bs      = cell_addr(o_cur_row, o_cur_col - CW'(1));
      accept    = i_valid & o_ready;
      printable = (i_char >= 8'h20) && (i_char <= 8'h7E);
   end

   // Reset aborts any write in flight and re-arms the screen clear from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_CLEAR;
         clr_k     <= '0;
         advance   <= 1'b0;
         o_ready   <= 1'b0;
         o_wr_req  <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_wr_be   <= '0;
         o_cur_col <= '0;
         o_cur_row <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               if (!o_wr_req) begin
                  o_wr_req  <= 1'b1;
                  o_wr_addr <= clear_addr(clr_k);
                  o_wr_data <= BLANK_W;
                  o_wr_be   <= 4'hF;
               end else if (i_wr_gnt) begin
                  if (clr_k == K_LAST) begin
                     state     <= S_IDLE;
                     clr_k     <= '0;
                     o_wr_req  <= 1'b0;
                     o_ready   <= 1'b1;
                     o_cur_col <= '0;
                     o_cur_row <= '0;
                  end else begin
                     clr_k     <= clr_k + KW'(1);
                     o_wr_addr <= clear_addr(clr_k + KW'(1));
                  end
               end
            end

            S_IDLE: begin
               if (accept) begin
                  if (i_char == CH_LF) begin
                     o_cur_col <= '0;
                     o_cur_row <= row_lf;
                  end else if (i_char == CH_CR) begin
                     o_cur_col <= '0;
                  end else if (i_char == CH_BS) begin
                     if (o_cur_col != '0) begin
                        o_cur_col <= o_cur_col - CW'(1);
                        state     <= S_WRITE;
                        advance   <= 1'b0;
                        o_ready   <= 1'b0;
                        o_wr_req  <= 1'b1;
                        o_wr_addr <= a_bs & 32'hFFFF_FFFC;
                        o_wr_data <= BLANK_W;
                        o_wr_be   <= 4'b0001 << a_bs[1:0];
                     end
                  end else if (i_char == CH_FF) begin
                     // Start the clear immediately so the request is continuous from the next cycle.
                     state     <= S_CLEAR;
                     clr_k     <= '0;
                     o_ready   <= 1'b0;
                     o_wr_req  <= 1'b1;
                     o_wr_addr <= clear_addr('0);
                     o_wr_data <= BLANK_W;
                     o_wr_be   <= 4'hF;
                  end else if (printable) begin
                     state     <= S_WRITE;
                     advance   <= 1'b1;
                     o_ready   <= 1'b0;
                     o_wr_req  <= 1'b1;
                     o_wr_addr <= a_cur & 32'hFFFF_FFFC;
                     o_wr_data <= {4{i_char}};
                     o_wr_be   <= 4'b0001 << a_cur[1:0];
                  end
               end
            end

            S_WRITE: begin
               if (i_wr_gnt) begin
                  state    <= S_IDLE;
                  o_wr_req <= 1'b0;
                  o_ready  <= 1'b1;
                  if (advance) begin
                     o_cur_col <= col_adv;
                     o_cur_row <= row_adv;
                  end
               end
            end

            default: begin
               state    <= S_CLEAR;
               clr_k    <= '0;
               o_wr_req <= 1'b0;
               o_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected writes are queued by the
// stimulus, and a monitor pops and compares on every granted write.
module tb_text_console_writer;

   localparam int COLS = 86;
   localparam int ROWS = 32;
   localparam int NW   = 688;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [7:0]  i_char = 8'h00;
   logic        i_wr_gnt = 1'b1;
   logic        o_ready;
   logic        o_wr_req;
   logic [31:0] o_wr_addr;
   logic [31:0] o_wr_data;
   logic [3:0]  o_wr_be;
   logic [6:0]  o_cur_col;
   logic [4:0]  o_cur_row;

   text_console_writer #(.COLS(COLS), .ROWS(ROWS), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_char(i_char), .o_ready(o_ready),
      .o_wr_req(o_wr_req), .i_wr_gnt(i_wr_gnt), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_wr_be(o_wr_be), .o_cur_col(o_cur_col), .o_cur_row(o_cur_row)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   wr_t q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;
   int  grants = 0;
   int  mr = 0;
   int  mc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: a write completes on the following rising edge when req & gnt.
   always @(negedge clk) begin
      if (rst_n && o_wr_req && i_wr_gnt) begin
         grants++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%h data=%h be=%b required none",
                     o_wr_addr, o_wr_data, o_wr_be);
         end else begin
            mon_e = q.pop_front();
            chk("wr_addr", o_wr_addr, mon_e.addr);
            chk("wr_data", o_wr_data, mon_e.data);
            chk("wr_be", 32'(o_wr_be), 32'(mon_e.be));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      int n = 0;
      while (!o_ready && n < 5000) begin
         tick();
         n++;
      end
      if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
      i_char  = c;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((!o_ready || q.size() != 0) && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic push_cell(input int r, input int c, input logic [7:0] ch);
      int  a;
      wr_t e;
      a      = r * COLS + c;
      e.addr = 32'(a) & ~32'h3;
      e.data = {4{ch}};
      e.be   = 4'b0001 << a[1:0];
      q.push_back(e);
   endtask

   task automatic push_lit(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      wr_t e;
      e.addr = addr;
      e.data = data;
      e.be   = be;
      q.push_back(e);
   endtask

   task automatic clear_expect();
      for (int k = 0; k < NW; k++) push_lit(32'(4 * k), 32'h2020_2020, 4'hF);
   endtask

   // Printable character through the model, waits for completion.
   task automatic pr(input logic [7:0] ch);
      push_cell(mr, mc, ch);
      send(ch);
      drain();
      if (mc == COLS - 1) begin
         mc = 0;
         mr = (mr == ROWS - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   task automatic lf();
      send(8'h0A);
      mc = 0;
      mr = (mr == ROWS - 1) ? 0 : mr + 1;
   endtask

   task automatic chk_cur(input string name, input int col, input int row);
      chk({name, "_col"}, 32'(o_cur_col), 32'(col));
      chk({name, "_row"}, 32'(o_cur_row), 32'(row));
   endtask

   task automatic count_clear(input string name);
      int cnt = 0;
      int n = 0;
      while (!o_ready && n < 3000) begin
         tick();
         if (o_wr_req) cnt++;
         n++;
      end
      chk(name, 32'(cnt), 32'(NW));
   endtask

   initial begin
      int g0;

      // Reset state
      rst_n    = 1'b0;
      i_wr_gnt = 1'b1;
      tick();
      tick();
      chk("rst_req", 32'(o_wr_req), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_addr", o_wr_addr, 32'd0);
      chk("rst_data", o_wr_data, 32'd0);
      chk("rst_be", 32'(o_wr_be), 32'd0);
      chk_cur("rst_cur", 0, 0);

      // Power-on clear
      clear_expect();
      rst_n = 1'b1;
      count_clear("init_clear_cycles");
      drain();
      chk("init_ready", 32'(o_ready), 32'd1);
      chk_cur("init_cur", 0, 0);

      // 'A' at (0,0)
      push_lit(32'h0, 32'h4141_4141, 4'b0001);
      send(8'h41);
      drain();
      mc = 1;
      chk_cur("after_A", 1, 0);

      // Move to (5,2), then 'B'
      send(8'h0D);
      mc = 0;
      lf();
      lf();
      for (int i = 0; i < 5; i++) pr(8'h20);
      push_lit(32'hB0, 32'h4242_4242, 4'b0010);
      send(8'h42);
      drain();
      mc = 6;
      chk_cur("after_B", 6, 2);

      // Grant stall on 'C' at (6,2)
      i_wr_gnt = 1'b0;
      push_lit(32'hB0, 32'h4343_4343, 4'b0100);
      send(8'h43);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", 32'(o_wr_req), 32'd1);
         chk("stall_addr", o_wr_addr, 32'hB0);
         chk("stall_data", o_wr_data, 32'h4343_4343);
         chk("stall_be", 32'(o_wr_be), 32'b0100);
         chk("stall_ready", 32'(o_ready), 32'd0);
         chk_cur("stall_cur", 6, 2);
         tick();
      end
      i_wr_gnt = 1'b1;
      drain();
      mc = 7;
      chk_cur("after_C", 7, 2);

      // Screen wrap at (85,31)
      for (int i = 0; i < 29; i++) lf();
      for (int i = 0; i < 85; i++) pr(8'h20);
      chk_cur("at_last", 85, 31);
      push_lit(32'hABC, 32'h5A5A_5A5A, 4'b1000);
      send(8'h5A);
      drain();
      mc = 0;
      mr = 0;
      chk_cur("after_Z", 0, 0);
      for (int i = 0; i < 31; i++) lf();
      chk_cur("row31", 0, 31);
      lf();
      chk_cur("lf_wrap", 0, 0);

      // Backspace / CR / ignored code at row 4
      for (int i = 0; i < 4; i++) lf();
      for (int i = 0; i < 3; i++) pr(8'h20);
      chk_cur("before_bs", 3, 4);
      push_lit(32'h158, 32'h2020_2020, 4'b0100);
      send(8'h08);
      chk("bs_col_on_accept", 32'(o_cur_col), 32'd2);
      drain();
      chk_cur("after_bs", 2, 4);
      send(8'h0D);
      chk("cr_ready", 32'(o_ready), 32'd1);
      chk_cur("after_cr", 0, 4);
      send(8'h08);
      chk("bs0_req", 32'(o_wr_req), 32'd0);
      chk_cur("after_bs0", 0, 4);
      send(8'h07);
      chk("bel_ready", 32'(o_ready), 32'd1);
      chk_cur("after_bel", 0, 4);
      for (int i = 0; i < 4; i++) tick();
      chk("ctl_no_write", 32'(q.size()), 32'd0);
      mc = 0;
      mr = 4;

      // Form feed with random grant stalls
      pr(8'h51);
      chk_cur("before_ff", 1, 4);
      g0 = grants;
      clear_expect();
      send(8'h0C);
      begin
         int n = 0;
         while (!o_ready && n < 20000) begin
            i_wr_gnt = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
      end
      i_wr_gnt = 1'b1;
      drain();
      chk("ff_grants", 32'(grants - g0), 32'(NW));
      chk_cur("after_ff", 0, 0);

      // Reset in the middle of a clear
      clear_expect();
      send(8'h0C);
      for (int i = 0; i < 100; i++) tick();
      chk("midclr_req_before", 32'(o_wr_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midclr_req_drop", 32'(o_wr_req), 32'd0);
      q.delete();
      tick();
      tick();
      chk("midclr_addr", o_wr_addr, 32'd0);
      chk("midclr_ready", 32'(o_ready), 32'd0);
      clear_expect();
      rst_n = 1'b1;
      count_clear("reclear_cycles");
      drain();
      chk_cur("after_reclear", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
